kf6845_register_bus_interface: RTL and testbench
================================================

// Module: kf6845_register_bus_interface
// PURPOSE
//  Parametrised 6800-style processor bus interface for the KF6845 CRTC family: address/data register
//  pair, ENABLE synchronisation, per-register write/read strobes, read-data return path, optional address
//  auto-increment. Sits between the CPU pins and the register/timing core; generalises register count,
//  data width and readability per register.
// PARAMETERS
//  DATA_WIDTH   8          processor data bus width
//  ADDR_WIDTH   5          address register width (DATA_WIDTH >= ADDR_WIDTH)
//  NUM_REGS     18         implemented registers, indices 0..NUM_REGS-1 (NUM_REGS <= 2**ADDR_WIDTH)
//  SYNC_STAGES  2          flip-flops in ENABLE synchroniser (>= 2)
//  READ_MASK    18'h3C000  bit i = 1: register i readable
//  AUTO_INC     0          1: address advances after every RS=1 access
// PORTS
//  clock             in   1                    system clock
//  reset_n           in   1                    asynchronous, active-low reset
//  CS_N              in   1                    chip select, active low
//  RS                in   1                    0 = address register, 1 = data register
//  ENABLE            in   1                    bus strobe E (asynchronous to clock)
//  R_OR_W            in   1                    1 = read, 0 = write
//  D_IN              in   DATA_WIDTH           write data from CPU
//  D_OUT             out  DATA_WIDTH           read data to CPU
//  D_OE              out  1                    read-data output enable
//  reg_write_strobe  out  NUM_REGS             one-hot, one-cycle write pulse
//  reg_write_data    out  DATA_WIDTH           data accompanying reg_write_strobe
//  reg_read_strobe   out  NUM_REGS             one-hot, one-cycle pulse at read capture (clear-on-read hooks)
//  reg_read_data     in   NUM_REGS*DATA_WIDTH  flattened register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//  address           out  ADDR_WIDTH           current address register
//  access_error      out  1                    one-cycle pulse: RS=1 access to index >= NUM_REGS
// BEHAVIOUR
//  Reset (async, reset_n=0): FSM IDLE; address=0; D_OUT=0; D_OE=0; all strobes 0; access_error=0.
//   Synchroniser cleared. Reset mid-access aborts the access without strobes.
//  ENABLE passes SYNC_STAGES flops -> en_s; rise = en_s & ~en_s_d, fall = ~en_s & en_s_d.
//  FSM IDLE -> ACTIVE on rise with CS_N=0; RS and R_OR_W captured at rise, frozen during ACTIVE.
//   Rise with CS_N=1 ignored (stay IDLE). ACTIVE -> IDLE on fall (commit cycle); no other exit except reset.
//  D_IN sampled every ACTIVE cycle while en_s=1; commit uses last sample (D_IN stable >= SYNC_STAGES+1 clocks before E falls).
//  Write, RS=0: at fall, address <= D_IN[ADDR_WIDTH-1:0]; no auto-increment.
//  Write, RS=1: at fall, index < NUM_REGS -> reg_write_strobe[address]=1 one cycle after fall, reg_write_data
//   = sampled data; index >= NUM_REGS -> no strobe, access_error pulse same cycle.
//  Read, RS=0: D_OUT <= zero-extended address the cycle after rise.
//  Read, RS=1: cycle after rise, D_OUT <= reg_read_data slice if index < NUM_REGS and READ_MASK[index], else 0;
//   reg_read_strobe[address] pulses that cycle only if readable; access_error pulses if index >= NUM_REGS.
//  D_OE = 1 from capture cycle until commit cycle inclusive of ACTIVE, only for reads; 0 otherwise.
//   D_OUT holds its value after the access.
//  AUTO_INC=1: in commit cycle of any RS=1 access (read or write, valid or error), address <= (address ==
//   NUM_REGS-1 || address >= NUM_REGS) ? 0 : address+1. Strobe uses pre-increment address.
//  Latency: write strobe = SYNC_STAGES+2 clocks after E falls at pin; read data = SYNC_STAGES+2 after E rises.
//  Write and read strobes never coincide; at most one strobe bit set in any cycle.
// STRUCTURE
//  Package kf6845_bus_pkg: typedef enum {IDLE, ACTIVE} bus_state_t; function reg_index_valid(addr, num_regs).
//  Sub-module kf6845_sync_chain (parameter STAGES, 1-bit, async active-low clear) for ENABLE.
//  Remainder flat: FSM, address register, capture/return path, strobe decode.
// TESTING
//  Write 0x0E to address (RS=0), then 0x12 with RS=1 -> address==14, reg_write_strobe==1<<14, data 0x12.
//  reg_read_data[15]=0x5A, address 15, read RS=1 -> D_OE=1, D_OUT=0x5A, reg_read_strobe==1<<15 for one cycle.
//  Read address 3 (READ_MASK bit 0) -> D_OUT=0x00, no read strobe, no access_error.
//  Address 0x1F, RS=1 write -> no write strobe, access_error one pulse; AUTO_INC=1 -> address becomes 0.
//  AUTO_INC=1, address 17, three RS=1 writes -> strobes at 17, 0, 1; final address 2.
//  reset_n low while ACTIVE mid-write -> no strobe, address=0, D_OE=0; next clean access works; CS_N=1 access ignored.

Source files
------------

// File: rtl/kf6845_bus_pkg.sv
// Shared types and helpers for the KF6845 processor bus interface.
package kf6845_bus_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } bus_state_t;

  // True when the address register points at an implemented register.
  function automatic logic reg_index_valid(input int addr, input int num_regs);
    return (addr < num_regs);
  endfunction

endpackage

// File: rtl/kf6845_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit, cleared on reset.
module kf6845_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_in,
  output logic q_out
);

  logic [STAGES-1:0] sh_q, sh_d;

  // Shift the raw input one stage deeper each clock.
  always_comb begin
    sh_d = {sh_q[STAGES-2:0], d_in};
  end

  // Synchroniser flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sh_q <= '0;
    else          sh_q <= sh_d;
  end

  assign q_out = sh_q[STAGES-1];

endmodule

// File: rtl/kf6845_register_bus_interface.sv
// 6800-style CPU bus front end for the KF6845 CRTC: address/data register
// pair, E-strobe synchronisation, per-register strobes and read return path.
module kf6845_register_bus_interface
  import kf6845_bus_pkg::*;
#(
  parameter int                  DATA_WIDTH  = 8,
  parameter int                  ADDR_WIDTH  = 5,
  parameter int                  NUM_REGS    = 18,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [NUM_REGS-1:0] READ_MASK   = 18'h3C000,
  parameter bit                  AUTO_INC    = 1'b0
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           CS_N,
  input  logic                           RS,
  input  logic                           ENABLE,
  input  logic                           R_OR_W,
  input  logic [DATA_WIDTH-1:0]          D_IN,
  output logic [DATA_WIDTH-1:0]          D_OUT,
  output logic                           D_OE,
  output logic [NUM_REGS-1:0]            reg_write_strobe,
  output logic [DATA_WIDTH-1:0]          reg_write_data,
  output logic [NUM_REGS-1:0]            reg_read_strobe,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_read_data,
  output logic [ADDR_WIDTH-1:0]          address,
  output logic                           access_error
);

  logic                  en_s;
  bus_state_t            state_q, state_d;
  logic                  en_d_q, rs_q, rs_d, rw_q, rw_d;
  logic                  first_q, first_d, commit_q, commit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, dout_q, dout_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d, addr_inc;
  logic                  doe_q, doe_d, err_q, err_d;
  logic [NUM_REGS-1:0]   wstb_q, wstb_d, rstb_q, rstb_d, onehot;
  logic                  rise, fall, idx_ok, rd_ok;
  logic [DATA_WIDTH-1:0] rd_slice;

  kf6845_sync_chain #(.STAGES(SYNC_STAGES)) u_en_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d_in   (ENABLE),
    .q_out  (en_s)
  );

  // Edge detect, register decode and read-data selection.
  always_comb begin
    rise     = en_s & ~en_d_q;
    fall     = ~en_s & en_d_q;
    idx_ok   = reg_index_valid(int'(address_q), NUM_REGS);
    onehot   = NUM_REGS'(1) << address_q;
    addr_inc = (idx_ok && address_q != ADDR_WIDTH'(NUM_REGS - 1)) ? address_q + 1'b1 : '0;
    rd_slice = '0;
    rd_ok    = 1'b0;
    // Mux loop rather than a variable part-select so out-of-range addresses read as zero.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (address_q == ADDR_WIDTH'(i)) begin
        rd_slice = reg_read_data[i*DATA_WIDTH +: DATA_WIDTH];
        rd_ok    = READ_MASK[i];
      end
    end
  end

  // Bus FSM: capture on E rise, read return in the first ACTIVE cycle, commit one cycle after E fall.
  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    rw_d      = rw_q;
    first_d   = 1'b0;
    commit_d  = 1'b0;
    data_d    = data_q;
    dout_d    = dout_q;
    doe_d     = doe_q;
    wdata_d   = wdata_q;
    address_d = address_q;
    wstb_d    = '0;
    rstb_d    = '0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise && !CS_N) begin
          state_d = ACTIVE;
          rs_d    = RS;
          rw_d    = R_OR_W;
          first_d = 1'b1;
          data_d  = D_IN;
        end
      end
      ACTIVE: begin
        if (en_s) data_d = D_IN;
        if (first_q && rw_q) begin
          doe_d = 1'b1;
          if (!rs_q) begin
            dout_d = DATA_WIDTH'(address_q);
          end else begin
            dout_d = (idx_ok && rd_ok) ? rd_slice : '0;
            rstb_d = (idx_ok && rd_ok) ? onehot : '0;
            err_d  = !idx_ok;
          end
        end
        if (fall) begin
          state_d  = IDLE;
          commit_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit_q) begin
      doe_d = 1'b0;
      if (rs_q) begin
        if (!rw_q) begin
          if (idx_ok) begin
            wstb_d  = onehot;
            wdata_d = data_q;
          end else begin
            err_d = 1'b1;
          end
        end
        if (AUTO_INC) address_d = addr_inc;
      end else if (!rw_q) begin
        address_d = data_q[ADDR_WIDTH-1:0];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      en_d_q    <= 1'b0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      first_q   <= 1'b0;
      commit_q  <= 1'b0;
      data_q    <= '0;
      dout_q    <= '0;
      doe_q     <= 1'b0;
      wdata_q   <= '0;
      address_q <= '0;
      wstb_q    <= '0;
      rstb_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_d_q    <= en_s;
      rs_q      <= rs_d;
      rw_q      <= rw_d;
      first_q   <= first_d;
      commit_q  <= commit_d;
      data_q    <= data_d;
      dout_q    <= dout_d;
      doe_q     <= doe_d;
      wdata_q   <= wdata_d;
      address_q <= address_d;
      wstb_q    <= wstb_d;
      rstb_q    <= rstb_d;
      err_q     <= err_d;
    end
  end

  assign D_OUT            = dout_q;
  assign D_OE             = doe_q;
  assign reg_write_strobe = wstb_q;
  assign reg_write_data   = wdata_q;
  assign reg_read_strobe  = rstb_q;
  assign address          = address_q;
  assign access_error     = err_q;

endmodule

// File: tb/tb_kf6845_register_bus_interface.sv
// Bench: two instances (AUTO_INC 0 and 1) share the CPU pins; a table of
// hand-derived vectors, a reset-abort sequence, random accesses against a
// rule-level model, and latency measurements.
module tb_kf6845_register_bus_interface;

  localparam int NR = 18;

  typedef struct {
    int addr; int wcnt; int widx; int wdat; int rcnt; int ridx;
    int ecnt; int doe; int dout; int doe_end;
  } res_t;

  typedef struct {
    logic cs; logic rs; logic rw; logic [7:0] din;
    int addr; int widx; int wdat; int ridx; int ecnt; int doe; int dout;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             CS_N = 1'b1, RS = 1'b0, ENABLE = 1'b0, R_OR_W = 1'b1;
  logic [7:0]       D_IN = '0;
  logic [NR*8-1:0]  rrd = '0;
  logic [7:0]       dout [2];
  logic             doe  [2];
  logic [NR-1:0]    wstb [2];
  logic [NR-1:0]    rstb [2];
  logic [7:0]       wdat [2];
  logic [4:0]       addr [2];
  logic             err  [2];

  int n_chk = 0, n_fail = 0, viol = 0;
  int wcnt_m[2] = '{0, 0}, widx_m[2] = '{0, 0}, wdat_m[2] = '{0, 0};
  int rcnt_m[2] = '{0, 0}, ridx_m[2] = '{0, 0}, ecnt_m[2] = '{0, 0};
  int maddr[2] = '{0, 0}, mdout[2] = '{0, 0};
  logic [NR-1:0] rmask = 18'h3C000;
  res_t obs[2];
  vec_t tbl[16];

  always #5 clock = ~clock;

  kf6845_register_bus_interface #(.AUTO_INC(1'b0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .CS_N(CS_N), .RS(RS), .ENABLE(ENABLE),
    .R_OR_W(R_OR_W), .D_IN(D_IN), .D_OUT(dout[0]), .D_OE(doe[0]),
    .reg_write_strobe(wstb[0]), .reg_write_data(wdat[0]), .reg_read_strobe(rstb[0]),
    .reg_read_data(rrd), .address(addr[0]), .access_error(err[0]));

  kf6845_register_bus_interface #(.AUTO_INC(1'b1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .CS_N(CS_N), .RS(RS), .ENABLE(ENABLE),
    .R_OR_W(R_OR_W), .D_IN(D_IN), .D_OUT(dout[1]), .D_OE(doe[1]),
    .reg_write_strobe(wstb[1]), .reg_write_data(wdat[1]), .reg_read_strobe(rstb[1]),
    .reg_read_data(rrd), .address(addr[1]), .access_error(err[1]));

  // Passive monitor: counts strobe/error pulses and one-hot violations.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (wstb[d] != '0) begin
        wcnt_m[d]++;
        for (int i = 0; i < NR; i++) if (wstb[d][i]) widx_m[d] = i;
        wdat_m[d] = int'(wdat[d]);
      end
      if (rstb[d] != '0) begin
        rcnt_m[d]++;
        for (int i = 0; i < NR; i++) if (rstb[d][i]) ridx_m[d] = i;
      end
      if (err[d]) ecnt_m[d]++;
      if ($countones(wstb[d]) + $countones(rstb[d]) > 1) viol++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cmp_res(input string tag, input res_t o, input res_t e);
    chk({tag, " addr"}, o.addr, e.addr);
    chk({tag, " wcnt"}, o.wcnt, e.wcnt);
    chk({tag, " widx"}, o.widx, e.widx);
    chk({tag, " wdat"}, o.wdat, e.wdat);
    chk({tag, " rcnt"}, o.rcnt, e.rcnt);
    chk({tag, " ridx"}, o.ridx, e.ridx);
    chk({tag, " err"},  o.ecnt, e.ecnt);
    chk({tag, " doe"},  o.doe,  e.doe);
    chk({tag, " dout"}, o.dout, e.dout);
    chk({tag, " doe_end"}, o.doe_end, e.doe_end);
  endtask

  // Reference model: applies the bus rules to the remembered address/D_OUT.
  task automatic model(input int d, input logic cs, input logic rs, input logic rw,
                       input logic [7:0] din, output res_t e);
    e = '{addr:0, wcnt:0, widx:-1, wdat:-1, rcnt:0, ridx:-1, ecnt:0, doe:0, dout:0, doe_end:0};
    if (!cs) begin
      if (rw) begin
        e.doe = 1;
        if (!rs) mdout[d] = maddr[d];
        else if (maddr[d] >= NR) begin mdout[d] = 0; e.ecnt = 1; end
        else if (rmask[maddr[d]]) begin
          mdout[d] = int'(rrd[maddr[d]*8 +: 8]); e.rcnt = 1; e.ridx = maddr[d];
        end else mdout[d] = 0;
      end else begin
        if (!rs) maddr[d] = din % 32;
        else if (maddr[d] < NR) begin e.wcnt = 1; e.widx = maddr[d]; e.wdat = din; end
        else e.ecnt = 1;
      end
      if (rs && d == 1) maddr[d] = (maddr[d] == NR - 1 || maddr[d] >= NR) ? 0 : maddr[d] + 1;
    end
    e.addr = maddr[d];
    e.dout = mdout[d];
  endtask

  // One complete bus cycle: E high 8 clocks, low 8 clocks; fills obs[].
  task automatic access(input logic cs, input logic rs, input logic rw, input logic [7:0] din);
    int w0[2], r0[2], e0[2];
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin w0[d] = wcnt_m[d]; r0[d] = rcnt_m[d]; e0[d] = ecnt_m[d]; end
    CS_N = cs; RS = rs; R_OR_W = rw; D_IN = din; ENABLE = 1'b1;
    repeat (6) @(negedge clock);
    for (int d = 0; d < 2; d++) obs[d].doe = int'(doe[d]);
    repeat (2) @(negedge clock);
    ENABLE = 1'b0;
    repeat (8) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      obs[d].wcnt = wcnt_m[d] - w0[d];
      obs[d].widx = obs[d].wcnt != 0 ? widx_m[d] : -1;
      obs[d].wdat = obs[d].wcnt != 0 ? wdat_m[d] : -1;
      obs[d].rcnt = rcnt_m[d] - r0[d];
      obs[d].ridx = obs[d].rcnt != 0 ? ridx_m[d] : -1;
      obs[d].ecnt = ecnt_m[d] - e0[d];
      obs[d].addr = int'(addr[d]);
      obs[d].dout = int'(dout[d]);
      obs[d].doe_end = int'(doe[d]);
    end
    CS_N = 1'b1;
  endtask

  initial begin
    res_t e0, e1, hv;
    int n, w0;
    logic cs, rs, rw;
    logic [7:0] din;

    //       cs    rs    rw    din    addr widx wdat  ridx err doe dout
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h0E, 14, -1,  -1,   -1, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h12, 14, 14,  8'h12,-1, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h0F, 15, -1,  -1,   -1, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 15, -1,  -1,   15, 0, 1, 8'h5A};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 15, -1,  -1,   -1, 0, 1, 8'h0F};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h03, 3,  -1,  -1,   -1, 0, 0, 8'h0F};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h00, 3,  -1,  -1,   -1, 0, 1, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h1F, 31, -1,  -1,   -1, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'hAA, 31, -1,  -1,   -1, 1, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h00, 31, -1,  -1,   -1, 1, 1, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h05, 31, -1,  -1,   -1, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'hE1, 1,  -1,  -1,   -1, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h11, 17, -1,  -1,   -1, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h30, 17, 17,  8'h30,-1, 0, 0, 0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h31, 17, 17,  8'h31,-1, 0, 0, 0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h32, 17, 17,  8'h32,-1, 0, 0, 0};

    for (int i = 0; i < NR; i++) rrd[i*8 +: 8] = 8'($urandom_range(0, 255));
    rrd[15*8 +: 8] = 8'h5A;
    rrd[3*8 +: 8]  = 8'h77;

    // Reset state.
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d addr", d), int'(addr[d]), 0);
      chk($sformatf("rst%0d dout", d), int'(dout[d]), 0);
      chk($sformatf("rst%0d doe", d), int'(doe[d]), 0);
      chk($sformatf("rst%0d wstb", d), int'(wstb[d]), 0);
      chk($sformatf("rst%0d rstb", d), int'(rstb[d]), 0);
      chk($sformatf("rst%0d err", d), int'(err[d]), 0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Hand-derived vectors for the non-incrementing instance; model for the other.
    for (int i = 0; i < 16; i++) begin
      access(tbl[i].cs, tbl[i].rs, tbl[i].rw, tbl[i].din);
      model(0, tbl[i].cs, tbl[i].rs, tbl[i].rw, tbl[i].din, e0);
      model(1, tbl[i].cs, tbl[i].rs, tbl[i].rw, tbl[i].din, e1);
      hv = '{addr:tbl[i].addr, wcnt:(tbl[i].widx >= 0) ? 1 : 0, widx:tbl[i].widx,
             wdat:tbl[i].wdat, rcnt:(tbl[i].ridx >= 0) ? 1 : 0, ridx:tbl[i].ridx,
             ecnt:tbl[i].ecnt, doe:tbl[i].doe, dout:tbl[i].dout, doe_end:0};
      cmp_res($sformatf("tbl%0d d0", i), obs[0], hv);
      cmp_res($sformatf("tbl%0d d1", i), obs[1], e1);
    end
    // Auto-increment from 17 wraps through 0,1 to 2.
    chk("autoinc final addr", int'(addr[1]), 2);
    chk("autoinc last widx", widx_m[1], 1);

    // Reset in the middle of a write aborts it.
    @(negedge clock);
    w0 = wcnt_m[0] + wcnt_m[1];
    CS_N = 1'b0; RS = 1'b1; R_OR_W = 1'b0; D_IN = 8'h44; ENABLE = 1'b1;
    repeat (6) @(negedge clock);
    reset_n = 1'b0;
    ENABLE = 1'b0;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort%0d addr", d), int'(addr[d]), 0);
      chk($sformatf("abort%0d doe", d), int'(doe[d]), 0);
      maddr[d] = 0; mdout[d] = 0;
    end
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    chk("abort no strobe", wcnt_m[0] + wcnt_m[1] - w0, 0);
    access(1'b0, 1'b0, 1'b0, 8'h10);
    model(0, 1'b0, 1'b0, 1'b0, 8'h10, e0); model(1, 1'b0, 1'b0, 1'b0, 8'h10, e1);
    cmp_res("post0", obs[0], e0); cmp_res("post1", obs[1], e1);
    access(1'b1, 1'b1, 1'b0, 8'h99);
    model(0, 1'b1, 1'b1, 1'b0, 8'h99, e0); model(1, 1'b1, 1'b1, 1'b0, 8'h99, e1);
    cmp_res("csoff0", obs[0], e0); cmp_res("csoff1", obs[1], e1);

    // Random accesses against the model.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0)
        for (int i = 0; i < NR; i++) rrd[i*8 +: 8] = 8'($urandom_range(0, 255));
      cs  = ($urandom_range(0, 7) == 0);
      rs  = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      din = ($urandom_range(0, 2) == 0) ? 8'(14 + $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      access(cs, rs, rw, din);
      model(0, cs, rs, rw, din, e0);
      model(1, cs, rs, rw, din, e1);
      cmp_res($sformatf("rnd%0d d0", k), obs[0], e0);
      cmp_res($sformatf("rnd%0d d1", k), obs[1], e1);
    end

    // Latency from E edges at the pin: SYNC_STAGES+2 = 4 clocks.
    access(1'b0, 1'b0, 1'b0, 8'h0F);
    @(negedge clock);
    CS_N = 1'b0; RS = 1'b1; R_OR_W = 1'b1; ENABLE = 1'b1;
    n = 0;
    while (!doe[0] && n < 20) begin @(negedge clock); n++; end
    chk("read latency", n, 4);
    chk("read latency data", int'(dout[0]), int'(rrd[15*8 +: 8]));
    repeat (4) @(negedge clock);
    ENABLE = 1'b0;
    repeat (8) @(negedge clock);
    R_OR_W = 1'b0; D_IN = 8'h3C; ENABLE = 1'b1;
    repeat (8) @(negedge clock);
    ENABLE = 1'b0;
    n = 0;
    while (wstb[0] == '0 && n < 20) begin @(negedge clock); n++; end
    chk("write latency", n, 4);
    chk("write latency strobe", int'(wstb[0]), 1 << 15);
    chk("write latency data", int'(wdat[0]), 8'h3C);
    repeat (4) @(negedge clock);
    CS_N = 1'b1;

    chk("one-hot strobe violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
